// File: rtl/sw_input_unit_if.sv
// Read-port bundle between sw_input_unit and whoever polls it (CPU datapath or display mux).
interface sw_input_unit_if;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (output rd_en, rd_addr, input rd_data, rd_valid);
  modport slave  (input rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/sw_input_unit.sv
// Slide-switch input unit: two-flop synchroniser, tick-paced per-bit debouncer,
// change-event tracking with read-clear pending bits, and a registered read port.
module sw_input_unit #(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 50000,
  parameter int DB_CNT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  sw_input_unit_if.slave   rd,
  output logic [WIDTH-1:0] sw_stable,
  output logic             irq
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CNT - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [CW-1:0]    db_cnt      [WIDTH];
  logic [CW-1:0]    db_cnt_next [WIDTH];
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] rd_clear;
  logic [15:0]      evt_cnt;
  logic [15:0]      evt_inc;
  logic [31:0]      rd_mux;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      tick_cnt <= '0;
    end else begin
      s1       <= sw_raw;
      s2       <= s1;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
  end

  // A bit flips only after DB_CNT consecutive tick samples disagree with it.
  always_comb begin
    accept  = '0;
    evt_inc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      db_cnt_next[i] = db_cnt[i];
      if (tick) begin
        if (s2[i] == sw_stable[i]) begin
          db_cnt_next[i] = '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_cnt_next[i] = '0;
          accept[i]      = 1'b1;
        end else begin
          db_cnt_next[i] = db_cnt[i] + CW'(1);
        end
      end
      evt_inc = evt_inc + 16'(accept[i]);
    end
    stable_next = sw_stable ^ accept;
  end

  // Reading pending clears only what was returned; a same-cycle new event survives.
  always_comb begin
    rd_clear = '0;
    case (rd.rd_addr)
      2'd0:    rd_mux = 32'(sw_stable);
      2'd1:    rd_mux = 32'(pending);
      2'd2:    rd_mux = {16'h0, evt_cnt};
      default: rd_mux = 32'h0;
    endcase
    if (rd.rd_en && (rd.rd_addr == 2'd1)) rd_clear = pending;
    pending_next = (pending & ~rd_clear) | accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_stable   <= '0;
      pending     <= '0;
      evt_cnt     <= '0;
      irq         <= 1'b0;
      rd.rd_data  <= '0;
      rd.rd_valid <= 1'b0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      sw_stable   <= stable_next;
      pending     <= pending_next;
      evt_cnt     <= evt_cnt + evt_inc;
      irq         <= |pending_next;
      rd.rd_valid <= rd.rd_en;
      if (rd.rd_en) rd.rd_data <= rd_mux;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= db_cnt_next[i];
    end
  end

endmodule

// File: tb/tb_sw_input_unit.sv
// Self-checking bench for sw_input_unit: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the switch unit.
module tb_sw_input_unit;
  localparam int WIDTH    = 16;
  localparam int TICK_DIV = 4;
  localparam int DB_CNT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw_raw = '0;
  logic [15:0] sw_stable;
  logic        irq;

  sw_input_unit_if bus ();

  sw_input_unit #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .DB_CNT(DB_CNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .rd        (bus.slave),
    .sw_stable (sw_stable),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: raw levels seen two samples late, ticks every TICK_DIV cycles,
  // a run length of disagreeing tick samples per switch.
  int          m_cyc = 0;
  int          m_run [16];
  int          m_evt = 0;
  logic [15:0] m_h1 = '0, m_h2 = '0, m_stable = '0, m_pend = '0;
  logic [15:0] m_acc, m_ret;
  logic [31:0] m_rd_data = '0;
  logic        m_rd_valid = 1'b0, m_irq = 1'b0, m_tick;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc = 0; m_evt = 0; m_h1 = '0; m_h2 = '0; m_stable = '0; m_pend = '0;
      m_rd_data = '0; m_rd_valid = 1'b0; m_irq = 1'b0;
      for (int i = 0; i < 16; i++) m_run[i] = 0;
    end else begin
      m_tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
      m_cyc  = m_cyc + 1;
      m_acc  = '0;
      if (m_tick) begin
        for (int i = 0; i < 16; i++) begin
          if (m_h2[i] == m_stable[i]) m_run[i] = 0;
          else if (m_run[i] + 1 >= DB_CNT) begin m_run[i] = 0; m_acc[i] = 1'b1; end
          else m_run[i] = m_run[i] + 1;
        end
      end
      m_ret = '0;
      m_rd_valid = bus.rd_en;
      if (bus.rd_en) begin
        case (bus.rd_addr)
          2'd0:    m_rd_data = {16'h0, m_stable};
          2'd1:    begin m_rd_data = {16'h0, m_pend}; m_ret = m_pend; end
          2'd2:    m_rd_data = 32'(m_evt);
          default: m_rd_data = 32'h0;
        endcase
      end
      m_stable = m_stable ^ m_acc;
      m_evt    = (m_evt + $countones(m_acc)) % 65536;
      m_pend   = (m_pend & ~m_ret) | m_acc;
      m_irq    = (m_pend != 16'h0);
      m_h2     = m_h1;
      m_h1     = sw_raw;
    end
  end

  task automatic rd_cycle(input logic [1:0] a);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    @(negedge clk);
    bus.rd_en   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sw_raw = 16'h0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (sw_stable !== 16'h0) begin errors++; $display("[TB] FAIL reset_stable: got %h want 0000", sw_stable); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
    for (int a = 0; a < 3; a++) begin
      rd_cycle(2'(a));
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_rd_valid%0d: got %b want 1", a, bus.rd_valid); end
      checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd_data%0d: got %h want 00000000", a, bus.rd_data); end
    end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_drop: got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_clean_edge();
    int n = 0;
    sw_raw = 16'h0001;
    while (sw_stable[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      checks++; if (sw_stable !== m_stable) begin errors++; $display("[TB] FAIL edge_track: got %h want %h", sw_stable, m_stable); end
    end
    checks++; if (n > 14) begin errors++; $display("[TB] FAIL edge_latency: got %0d cycles want <= 14", n); end
    checks++; if (sw_stable !== 16'h0001) begin errors++; $display("[TB] FAIL edge_stable: got %h want 0001", sw_stable); end
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL edge_irq: got %b want 1", irq); end
    rd_cycle(2'd2);
    checks++; if (bus.rd_data !== 32'h1) begin errors++; $display("[TB] FAIL edge_evt: got %h want 00000001", bus.rd_data); end
    rd_cycle(2'd1);
    checks++; if (bus.rd_data !== 32'h1) begin errors++; $display("[TB] FAIL edge_pending: got %h want 00000001", bus.rd_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL edge_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_bounce();
    for (int t = 0; t < 10; t++) begin
      sw_raw[3] = (t % 2 == 0);
      repeat (4) begin
        @(negedge clk);
        checks++; if (sw_stable !== m_stable) begin errors++; $display("[TB] FAIL bounce_track: got %h want %h", sw_stable, m_stable); end
      end
    end
    sw_raw[3] = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (sw_stable[3] !== 1'b0) begin errors++; $display("[TB] FAIL bounce_stable3: got %b want 0", sw_stable[3]); end
    rd_cycle(2'd1);
    checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("[TB] FAIL bounce_pending: got %h want 00000000", bus.rd_data); end
    rd_cycle(2'd2);
    checks++; if (bus.rd_data !== 32'h1) begin errors++; $display("[TB] FAIL bounce_evt: got %h want 00000001", bus.rd_data); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0)
        sw_raw = sw_raw ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      bus.rd_en   = ($urandom_range(0, 2) == 0);
      bus.rd_addr = 2'($urandom_range(0, 3));
      @(negedge clk);
      checks++; if (sw_stable !== m_stable) begin errors++; $display("[TB] FAIL rand_stable: got %h want %h", sw_stable, m_stable); end
      checks++; if (irq !== m_irq) begin errors++; $display("[TB] FAIL rand_irq: got %b want %b", irq, m_irq); end
      checks++; if (bus.rd_valid !== m_rd_valid) begin errors++; $display("[TB] FAIL rand_valid: got %b want %b", bus.rd_valid, m_rd_valid); end
      checks++; if (bus.rd_data !== m_rd_data) begin errors++; $display("[TB] FAIL rand_data: got %h want %h", bus.rd_data, m_rd_data); end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 4; a++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = 2'(a);
      @(negedge clk);
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid%0d: got %b want 1", a, bus.rd_valid); end
      checks++; if (bus.rd_data !== m_rd_data) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h want %h", a, bus.rd_data, m_rd_data); end
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_valid: got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("[TB] FAIL b2b_hold: got %h want 00000000", bus.rd_data); end
  endtask

  task automatic test_read_clear_race();
    int n = 0;
    sw_raw = 16'h0000;
    pulse_reset();
    sw_raw = 16'h0001;
    while (sw_stable[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n >= 40) begin errors++; $display("[TB] FAIL race_setup: got timeout want bit0 stable"); end
    sw_raw = 16'h0021;
    n = 0;
    // Stop on the cycle right before the tick that will accept bit 5.
    while (!(m_run[5] == DB_CNT - 1 && (m_cyc % TICK_DIV) == TICK_DIV - 1 && m_h2[5] == 1'b1) && n < 40) begin
      @(negedge clk); n++;
    end
    checks++; if (n >= 40) begin errors++; $display("[TB] FAIL race_align: got timeout want accept edge"); end
    rd_cycle(2'd1);
    checks++; if (bus.rd_data !== 32'h1) begin errors++; $display("[TB] FAIL race_first_read: got %h want 00000001", bus.rd_data); end
    checks++; if (sw_stable !== 16'h0021) begin errors++; $display("[TB] FAIL race_stable: got %h want 0021", sw_stable); end
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL race_irq_hold: got %b want 1", irq); end
    rd_cycle(2'd1);
    checks++; if (bus.rd_data !== 32'h20) begin errors++; $display("[TB] FAIL race_second_read: got %h want 00000020", bus.rd_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL race_irq_drop: got %b want 0", irq); end
  endtask

  task automatic test_wrap();
    logic [15:0] mask;
    int n;
    sw_raw = 16'h0000;
    pulse_reset();
    // 4094*16 + 14 + 14 + 3 = 65535 events, leaving bits 1:0 low.
    for (int r = 0; r < 4097; r++) begin
      mask   = (r < 4094) ? 16'hFFFF : ((r < 4096) ? 16'hFFFC : 16'h001C);
      sw_raw = sw_raw ^ mask;
      n = 0;
      while (sw_stable !== sw_raw && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (n >= 30 || sw_stable !== m_stable) begin
        errors++;
        $display("[TB] FAIL wrap_round%0d: got %h want %h", r, sw_stable, m_stable);
        break;
      end
    end
    rd_cycle(2'd2);
    checks++; if (bus.rd_data !== 32'h0000FFFF) begin errors++; $display("[TB] FAIL wrap_preload: got %h want 0000ffff", bus.rd_data); end
    rd_cycle(2'd1);
    checks++; if (bus.rd_data !== 32'h0000FFFF) begin errors++; $display("[TB] FAIL wrap_pending_all: got %h want 0000ffff", bus.rd_data); end
    sw_raw = sw_raw | 16'h0003;
    n = 0;
    while (sw_stable !== sw_raw && n < 30) begin @(negedge clk); n++; end
    rd_cycle(2'd2);
    checks++; if (bus.rd_data !== 32'h1) begin errors++; $display("[TB] FAIL wrap_evt: got %h want 00000001", bus.rd_data); end
    rd_cycle(2'd1);
    checks++; if (bus.rd_data !== 32'h3) begin errors++; $display("[TB] FAIL wrap_pending: got %h want 00000003", bus.rd_data); end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    sw_raw = 16'h0000;
    pulse_reset();
    sw_raw = 16'h0080;
    while (m_run[7] != 2 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n >= 40) begin errors++; $display("[TB] FAIL midrst_setup: got timeout want two ticks counted"); end
    pulse_reset();
    checks++; if (sw_stable !== 16'h0) begin errors++; $display("[TB] FAIL midrst_stable: got %h want 0000", sw_stable); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL midrst_irq: got %b want 0", irq); end
    for (int a = 0; a < 3; a++) begin
      rd_cycle(2'(a));
      checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("[TB] FAIL midrst_rd%0d: got %h want 00000000", a, bus.rd_data); end
    end
    // Sync refills by edge 1; ticks at edges 3, 7, 11 accept on the third.
    repeat (8) @(negedge clk);
    checks++; if (sw_stable !== 16'h0) begin errors++; $display("[TB] FAIL midrst_early: got %h want 0000", sw_stable); end
    @(negedge clk);
    checks++; if (sw_stable !== 16'h0080) begin errors++; $display("[TB] FAIL midrst_rise: got %h want 0080", sw_stable); end
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL midrst_irq_rise: got %b want 1", irq); end
    rd_cycle(2'd2);
    checks++; if (bus.rd_data !== 32'h1) begin errors++; $display("[TB] FAIL midrst_evt: got %h want 00000001", bus.rd_data); end
  endtask

  initial begin
    bus.rd_en   = 1'b0;
    bus.rd_addr = 2'd0;
    test_reset();
    test_clean_edge();
    test_bounce();
    test_random();
    test_back_to_back();
    test_read_clear_race();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
